// File: rtl/isa_pkg.sv
// ISA constants shared by the IF/ID stage: opcodes, immediate-select codes, field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_IN    = 6'h30;

    localparam logic [1:0] IMSEL_26  = 2'b00;
    localparam logic [1:0] IMSEL_20  = 2'b01;
    localparam logic [1:0] IMSEL_14  = 2'b10;
    localparam logic [1:0] IMSEL_EXT = 2'b11;

    // Bit positions within the 32-bit instruction word
    localparam int OP_LSB = 26;
    localparam int RA_LSB = 20;
    localparam int RB_LSB = 14;
    localparam int RC_LSB = 8;

    // Decoded instruction as carried by each buffer entry.
    // im26 holds instr[25:0]; ra/rb/rc/im20/im14 are all sub-slices of it.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] im26;
        logic [1:0]  imsel;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field slicer and immediate-select decoder (ILLEGAL_OP_EN adds opcode check).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input every cycle.
module instr_field_decode
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    // Slice fields and pick the immediate width from the opcode
    always_comb begin
        dec         = '0;
        dec.opcode  = instr[31:OP_LSB];
        dec.im26    = instr[25:0];
        dec.imsel   = IMSEL_26;
        dec.illegal = 1'b0;
        case (instr[31:OP_LSB])
            OP_RTYPE,
            OP_JMP:   dec.imsel = IMSEL_26;
            OP_LW,
            OP_SW,
            OP_ADDI:  dec.imsel = IMSEL_20;
            OP_BEQ:   dec.imsel = IMSEL_14;
            OP_IN:    dec.imsel = IMSEL_EXT;
            default: begin
                dec.imsel = IMSEL_26;
`ifdef ILLEGAL_OP_EN
                dec.illegal = 1'b1;
`else
                dec.illegal = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_reg.sv
// IF/ID stage: 2-entry skid buffer of decoded instructions + PC (ILLEGAL_OP_EN enables illegal flag).
// Latency: 1 cycle from accepted push to head outputs when buffer is empty.
// Backpressure: in_ready drops when both entries are full; flush empties the buffer next edge.
module instr_decode_reg
    import isa_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [REG_AW-1:0] ra,
    output logic [REG_AW-1:0] rb,
    output logic [REG_AW-1:0] rc,
    output logic [25:0]       im26,
    output logic [19:0]       im20,
    output logic [13:0]       im14,
    output logic [1:0]        IMSel,
    output logic [PC_W-1:0]   pc_out,
    output logic              illegal
);

    dec_t            push_dec;
    dec_t            head_dec;
    dec_t            skid_dec;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] skid_pc;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    instr_field_decode u_decode (
        .instr (in_instr),
        .dec   (push_dec)
    );

    // Handshake qualifiers; a flush swallows any push in the same cycle
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready;
    end

    // Skid buffer: head is slot0, skid is slot1; contents are kept when emptied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head_dec <= '0;
            skid_dec <= '0;
            head_pc  <= '0;
            skid_pc  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head_dec <= push_dec;
                        head_pc  <= in_pc;
                        count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_dec <= push_dec;
                        head_pc  <= in_pc;
                    end else if (push) begin
                        skid_dec <= push_dec;
                        skid_pc  <= in_pc;
                        count    <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push possible, a pop promotes the skid entry
                    if (pop) begin
                        head_dec <= skid_dec;
                        head_pc  <= skid_pc;
                        count    <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Head entry drives the decode-facing outputs directly
    always_comb begin
        opcode  = head_dec.opcode;
        im26    = head_dec.im26;
        ra      = head_dec.im26[RA_LSB +: REG_AW];
        rb      = head_dec.im26[RB_LSB +: REG_AW];
        rc      = head_dec.im26[RC_LSB +: REG_AW];
        im20    = head_dec.im26[19:0];
        im14    = head_dec.im26[13:0];
        IMSel   = head_dec.imsel;
        illegal = head_dec.illegal;
        pc_out  = head_pc;
    end

endmodule

// File: tb/tb_instr_decode_reg.sv
module tb_instr_decode_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [5:0]  rc;
    logic [25:0] im26;
    logic [19:0] im20;
    logic [13:0] im14;
    logic [1:0]  IMSel;
    logic [31:0] pc_out;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    instr_decode_reg #(.PC_W(32), .REG_AW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .im26      (im26),
        .im20      (im20),
        .im14      (im14),
        .IMSel     (IMSel),
        .pc_out    (pc_out),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then sample 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // streaming table: instr, pc, expected opcode, expected IMSel
    logic [31:0] s_instr [4] = '{32'h0BAD_CAFE, 32'hC012_3456, 32'hAC00_0008, 32'h0022_1800};
    logic [31:0] s_pc    [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [5:0]  s_op    [4] = '{6'h02, 6'h30, 6'h2B, 6'h00};
    logic [1:0]  s_sel   [4] = '{2'b00, 2'b11, 2'b01, 2'b00};
    logic        exp_ill;

    initial begin
`ifdef ILLEGAL_OP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imsel", IMSel, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        step();

        // single LW, consumed immediately
        in_valid = 1'b1; in_instr = 32'h8C22_0010; in_pc = 32'h40; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lw_valid", out_valid, 1);
        chk("lw_opcode", opcode, 6'h23);
        chk("lw_imsel", IMSel, 2'b01);
        chk("lw_im20", im20, 20'h20010);
        chk("lw_ra", ra, 6'h02);
        chk("lw_rb", rb, 6'h08);
        chk("lw_pc", pc_out, 32'h40);
        step();
        chk("lw_popped", out_valid, 0);
        chk("empty_hold_opcode", opcode, 6'h23);

        // fill both entries with decode stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1000_3FFC; in_pc = 32'h44;
        step();
        chk("beq_in_ready", in_ready, 1);
        in_instr = 32'h2041_0005; in_pc = 32'h48;
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_head_op", opcode, 6'h04);
        in_instr = 32'h0800_1234; in_pc = 32'h4C;   // ignored while full
        step();
        chk("full_still", in_ready, 0);
        chk("beq_imsel", IMSel, 2'b10);
        chk("beq_im14", im14, 14'h3FFC);
        chk("beq_pc", pc_out, 32'h44);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_opcode", opcode, 6'h08);
        chk("addi_imsel", IMSel, 2'b01);
        chk("addi_im20", im20, 20'h10005);
        chk("addi_pc", pc_out, 32'h48);
        chk("addi_in_ready", in_ready, 1);
        step();
        chk("drained", out_valid, 0);

        // streaming at one per cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = s_instr[i]; in_pc = s_pc[i];
            step();
            chk("strm_valid", out_valid, 1);
            chk("strm_in_ready", in_ready, 1);
            chk("strm_opcode", opcode, s_op[i]);
            chk("strm_imsel", IMSel, s_sel[i]);
            chk("strm_pc", pc_out, s_pc[i]);
        end
        chk("jmp_none_rc", rc, 6'h18);
        in_valid = 1'b0;
        step();
        chk("strm_drained", out_valid, 0);
        chk("in_im26_hold", im26, 26'h0221800);

        // flush while full with a simultaneous push
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h8C00_0001; in_pc = 32'h70;
        step();
        in_instr = 32'h8C00_0002; in_pc = 32'h74;
        step();
        chk("pre_flush_full", in_ready, 0);
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h8C00_0003; in_pc = 32'h80;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_empty", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        step();
        chk("flush_lost", out_valid, 0);
        in_valid = 1'b1; in_instr = 32'h8C00_0004; in_pc = 32'h90;
        step();
        in_valid = 1'b0;
        chk("post_flush_pc", pc_out, 32'h90);
        step();

        // opcode outside the table
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFC00_0000; in_pc = 32'hA0;
        step();
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_opcode", opcode, 6'h3F);
        chk("ill_flag", illegal, exp_ill);
        chk("ill_imsel", IMSel, 2'b00);

        // asynchronous reset with an entry held
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_imsel", IMSel, 0);
        chk("arst_illegal", illegal, 0);
        rst_n = 1'b1;
        step();
        chk("arst_stays_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
